pk_mm_sequencer: RTL and testbench
==================================

Name: pk_mm_sequencer

Overview:
- Drives the public/private multiply stage (2 × 16-bit A coefficients times 2 binary secret bits per beat) across a full polynomial pair.
- On start, walks every (A word, s word) pair and issues BRAM read addresses. It aligns valid, index and tag signals to the BRAM read latency.
- Tracks in-flight products until every B result has returned, then pulses done.
- Sits between the top-level control FSM and the A/s BRAMs plus the multiply stage.

Parameters:
- N_WORDS, 50, words per polynomial; each word holds 2 coefficients, so 100 coefficients total.
- BRAM_LAT, 2, cycles from address to data at the A and s BRAM outputs; legal range 1..4.
- IDX_W, 10, coefficient index width on the multiply stage.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  begin a run; sampled only in IDLE
- stall_in  in  1  downstream accumulator back-pressure; pauses issue only
- a_addr_out  out  $clog2(N_WORDS)  A BRAM word address
- s_addr_out  out  $clog2(N_WORDS)  s BRAM word address
- mm_A_valid_out  out  1  A data valid to the multiply stage
- mm_s_valid_out  out  1  s data valid to the multiply stage; identical to mm_A_valid_out
- mm_A_idx_out  out  IDX_W  coefficient index of the A word, equal to 2*i
- mm_s_idx_out  out  IDX_W  coefficient index of the s word, equal to 2*j
- mm_h_out  out  IDX_W  tag: bit IDX_W-1 = last-product flag, low bits = j
- mm_B_valid_in  in  1  result-valid return from the multiply stage
- busy_out  out  1  high from accepted start until done
- done_out  out  1  one-cycle pulse when the run has fully drained
- err_out  out  1  sticky: a result returned with nothing outstanding

Behaviour:
- Reset values: all outputs 0; state IDLE; i, j, outstanding counter cleared; delay line flushed.
- States and transitions:
  - IDLE: start_in=1 → ISSUE; i=j=0; busy_out=1.
  - ISSUE: each cycle with stall_in=0, issue one pair:
    - a_addr_out=i, s_addr_out=j.
    - i increments; at i=N_WORDS-1, i wraps to 0 and j increments.
    - Issue order: i inner loop, j outer loop.
    - Issuing pair (N_WORDS-1, N_WORDS-1) → DRAIN.
  - ISSUE with stall_in=1: no issue; addresses hold their last values.
  - DRAIN: waits until the delay line is empty and outstanding==0, then → DONE.
  - DONE: done_out=1 for one cycle, busy_out drops → IDLE.
- Alignment:
  - An issue at cycle t places valid=1, idx_A=2*i, idx_s=2*j and the tag on the mm_* outputs at cycle t+BRAM_LAT.
  - Non-issue cycles propagate valid=0; idx and tag are don't-care.
- Stall scope: stall_in never freezes the delay line; in-flight beats always emerge.
- Outstanding counter:
  - Width is $clog2(N_WORDS*N_WORDS+1).
  - +1 per issue, -1 per mm_B_valid_in; both in the same cycle → unchanged.
  - mm_B_valid_in at 0 → counter stays 0 and err_out sets. err_out clears only on rst_in or an accepted start.
- Last flag: set only on the tag for pair (N_WORDS-1, N_WORDS-1).
- start_in while busy: ignored, no effect on counters.
- Reset mid-run: immediately IDLE, valids drop the next cycle, no done pulse.
- Multiply-stage latency: the fixed 1-cycle latency is not assumed; the counter handles any latency.

Decomposition:
- Package pk_mm_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - COEF_PER_WORD=2
  - localparam helpers for address and counter widths
- Sub-module pk_mm_delay_line, parameterised on width and depth. It carries {valid, A_idx, s_idx, tag} for BRAM_LAT cycles and is cleared by rst_in.

Test Plan:
- N_WORDS=2, BRAM_LAT=2, no stall, multiply stage returns 1 cycle after valid:
  - addresses (i,j) = (0,0),(1,0),(0,1),(1,1) on consecutive cycles;
  - mm_A_idx 0,2,0,2 and mm_s_idx 0,0,2,2 appear 2 cycles later;
  - last flag only on the 4th beat;
  - done_out pulses once, 1 cycle after the 4th return; err_out=0.
- stall_in=1 for 3 cycles after the 2nd issue:
  - exactly 4 valid beats total, with a 3-cycle gap between beats 2 and 3;
  - already-issued beats are not delayed.
- rst_in asserted mid-ISSUE:
  - next cycle busy_out=0, all valids 0;
  - no done pulse;
  - a new start runs a full, correct sequence.
- Spurious mm_B_valid_in in IDLE → err_out=1 and stays set; the counter reads 0; the next start clears err_out.
- start_in pulsed again during ISSUE → order and count are unchanged, with exactly one done_out.
- Back-to-back runs with start_in high the cycle after done → the second run is identical to the first, with N_WORDS² beats.

Source files
------------

// File: rtl/pk_mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pk_mm_pkg
//  Purpose  : Shared types and width helpers for the public/private
//             multiply-stage sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pk_mm_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Each BRAM word packs two polynomial coefficients
    localparam int COEF_PER_WORD = 2;

    // Word-address width; never narrower than one bit
    function automatic int addr_width(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

    // Outstanding-product counter must hold every pair of a full run
    function automatic int cnt_width(input int n_words);
        return $clog2(n_words * n_words + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pk_mm_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : pk_mm_delay_line
//  Purpose  : Fixed-depth shift register that carries an issued beat
//             (valid in the MSB) until the BRAM data it belongs to arrives.
//  Revision : 1.0  initial release
// ============================================================================
module pk_mm_delay_line #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift every cycle; back-pressure never holds beats already in flight
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    // Busy while any stage still holds a valid beat
    always_comb begin
        o_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            o_busy = o_busy | r_pipe[k][WIDTH-1];
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pk_mm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pk_mm_sequencer
//  Purpose  : Walks every (A word, s word) pair, issues BRAM addresses,
//             realigns valid/index/tag to the BRAM latency and counts
//             in-flight products until the run has fully drained.
//  Revision : 1.0  initial release
// ============================================================================
module pk_mm_sequencer
    import pk_mm_pkg::*;
#(
    parameter int N_WORDS  = 50,
    parameter int BRAM_LAT = 2,
    parameter int IDX_W    = 10
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start_in,
    input  logic                           stall_in,
    output logic [addr_width(N_WORDS)-1:0] a_addr_out,
    output logic [addr_width(N_WORDS)-1:0] s_addr_out,
    output logic                           mm_A_valid_out,
    output logic                           mm_s_valid_out,
    output logic [IDX_W-1:0]               mm_A_idx_out,
    output logic [IDX_W-1:0]               mm_s_idx_out,
    output logic [IDX_W-1:0]               mm_h_out,
    input  logic                           mm_B_valid_in,
    output logic                           busy_out,
    output logic                           done_out,
    output logic                           err_out
);

    localparam int c_ADDR_W = addr_width(N_WORDS);
    localparam int c_CNT_W  = cnt_width(N_WORDS);
    localparam int c_BEAT_W = 1 + 3 * IDX_W;
    // One extra stage covers the address register ahead of the BRAM
    localparam int c_DEPTH  = BRAM_LAT + 1;
    localparam logic [c_ADDR_W-1:0] c_LAST_WORD = c_ADDR_W'(N_WORDS - 1);

    state_t               r_state;
    logic [c_ADDR_W-1:0]  r_i;
    logic [c_ADDR_W-1:0]  r_j;
    logic [c_CNT_W-1:0]   r_outstanding;

    logic                 w_issue;
    logic                 w_last_pair;
    logic                 w_ret_ok;
    logic                 w_spurious;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_pipe_busy;
    logic                 w_drained;
    logic [IDX_W-1:0]     w_a_idx;
    logic [IDX_W-1:0]     w_s_idx;
    logic [IDX_W-1:0]     w_tag;
    logic [c_BEAT_W-1:0]  w_beat_in;
    logic [c_BEAT_W-1:0]  w_beat_out;

    assign w_issue     = (r_state == ISSUE) && !stall_in;
    assign w_last_pair = (r_i == c_LAST_WORD) && (r_j == c_LAST_WORD);
    assign w_ret_ok    = mm_B_valid_in && (r_outstanding != '0);
    assign w_spurious  = mm_B_valid_in && (r_outstanding == '0);

    assign w_a_idx   = IDX_W'(int'(r_i) * COEF_PER_WORD);
    assign w_s_idx   = IDX_W'(int'(r_j) * COEF_PER_WORD);
    assign w_tag     = {w_last_pair, (IDX_W-1)'(r_j)};
    assign w_beat_in = {w_issue, w_a_idx, w_s_idx, w_tag};

    // Next outstanding count; a simultaneous issue and return cancel out
    always_comb begin
        w_cnt_next = r_outstanding;
        if (w_issue && !w_ret_ok) begin
            w_cnt_next = r_outstanding + c_CNT_W'(1);
        end else if (!w_issue && w_ret_ok) begin
            w_cnt_next = r_outstanding - c_CNT_W'(1);
        end
    end

    // Look at the post-update count so done follows the final return by one cycle
    assign w_drained = !w_pipe_busy && (w_cnt_next == '0);

    // Control FSM with address, counter and status registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= IDLE;
            r_i           <= '0;
            r_j           <= '0;
            r_outstanding <= '0;
            a_addr_out    <= '0;
            s_addr_out    <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            err_out       <= 1'b0;
        end else begin
            r_outstanding <= w_cnt_next;
            done_out      <= 1'b0;
            if (w_spurious) begin
                err_out <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_state  <= ISSUE;
                        r_i      <= '0;
                        r_j      <= '0;
                        busy_out <= 1'b1;
                        err_out  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!stall_in) begin
                        a_addr_out <= r_i;
                        s_addr_out <= r_j;
                        if (w_last_pair) begin
                            r_state <= DRAIN;
                        end else if (r_i == c_LAST_WORD) begin
                            r_i <= '0;
                            r_j <= r_j + c_ADDR_W'(1);
                        end else begin
                            r_i <= r_i + c_ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state  <= DONE;
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    pk_mm_delay_line #(
        .WIDTH (c_BEAT_W),
        .DEPTH (c_DEPTH)
    ) u_delay (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_data (w_beat_in),
        .o_data (w_beat_out),
        .o_busy (w_pipe_busy)
    );

    assign mm_A_valid_out = w_beat_out[c_BEAT_W-1];
    assign mm_s_valid_out = w_beat_out[c_BEAT_W-1];
    assign mm_A_idx_out   = w_beat_out[3*IDX_W-1:2*IDX_W];
    assign mm_s_idx_out   = w_beat_out[2*IDX_W-1:IDX_W];
    assign mm_h_out       = w_beat_out[IDX_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_pk_mm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pk_mm_sequencer
//  Purpose  : Self-checking bench for pk_mm_sequencer (N_WORDS=2,
//             BRAM_LAT=2), multiply stage echoed back one cycle after valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pk_mm_sequencer;

    localparam int N   = 2;
    localparam int LAT = 2;
    localparam int IW  = 10;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic          stall_in;
    logic [0:0]    a_addr_out;
    logic [0:0]    s_addr_out;
    logic          mm_A_valid_out;
    logic          mm_s_valid_out;
    logic [IW-1:0] mm_A_idx_out;
    logic [IW-1:0] mm_s_idx_out;
    logic [IW-1:0] mm_h_out;
    logic          mm_B_valid_in = 1'b0;
    logic          busy_out;
    logic          done_out;
    logic          err_out;

    pk_mm_sequencer #(
        .N_WORDS  (N),
        .BRAM_LAT (LAT),
        .IDX_W    (IW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .stall_in       (stall_in),
        .a_addr_out     (a_addr_out),
        .s_addr_out     (s_addr_out),
        .mm_A_valid_out (mm_A_valid_out),
        .mm_s_valid_out (mm_s_valid_out),
        .mm_A_idx_out   (mm_A_idx_out),
        .mm_s_idx_out   (mm_s_idx_out),
        .mm_h_out       (mm_h_out),
        .mm_B_valid_in  (mm_B_valid_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int a_idx;
        int s_idx;
        bit last;
        int due;
    } beat_t;

    typedef struct {
        int stall_after;
        int stall_len;
        int repulse;
        int exp_beats;
        int exp_dones;
    } vec_t;

    beat_t q[$];
    vec_t  vecs[3];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int beats    = 0;
    int dones    = 0;
    int exp_done = -1;
    int m_state  = 0;
    int m_k      = 0;
    int m_a      = 0;
    int m_s      = 0;
    bit m_err    = 1'b0;
    bit spur     = 1'b0;
    bit echo_prev = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    // Reference model: predicts issued pairs and pushes expected beats
    always @(posedge clk_in) begin : model_blk
        beat_t b;
        if (rst_in) begin
            m_state  = 0;
            q.delete();
            exp_done = -1;
            m_a      = 0;
            m_s      = 0;
            m_err    = 1'b0;
        end else begin
            if (spur) m_err = 1'b1;
            case (m_state)
                0: if (start_in) begin
                    m_state = 1;
                    m_k     = 0;
                    m_err   = 1'b0;
                end
                1: if (!stall_in) begin
                    b.a_idx = 2 * (m_k % N);
                    b.s_idx = 2 * (m_k / N);
                    b.last  = (m_k == N * N - 1);
                    b.due   = cyc + 1 + LAT;
                    q.push_back(b);
                    m_a = m_k % N;
                    m_s = m_k / N;
                    m_k++;
                    if (m_k == N * N) m_state = 2;
                end
                2: if (cyc == exp_done) m_state = 0;
                default: m_state = 0;
            endcase
        end
        cyc = cyc + 1;
    end

    // Monitor: pop and compare beats, check status, echo results back
    always @(negedge clk_in) begin : mon_blk
        beat_t b;
        if (cyc > 0) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                chk("missing_beat_due", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (mm_A_valid_out) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = q.pop_front();
                    chk("beat_cycle", cyc, b.due);
                    chk("A_idx", int'(mm_A_idx_out), b.a_idx);
                    chk("s_idx", int'(mm_s_idx_out), b.s_idx);
                    chk("h_last", int'(mm_h_out[IW-1]), int'(b.last));
                    chk("h_j", int'(mm_h_out[IW-2:0]), b.s_idx / 2);
                    beats++;
                    if (b.last) exp_done = cyc + 2;
                end
            end
            chk("s_valid_eq", int'(mm_s_valid_out), int'(mm_A_valid_out));
            chk("a_addr", int'(a_addr_out), m_a);
            chk("s_addr", int'(s_addr_out), m_s);
            chk("busy", int'(busy_out),
                int'((m_state == 1 || m_state == 2) && cyc != exp_done));
            chk("err", int'(err_out), int'(m_err));
            if (done_out || cyc == exp_done) begin
                chk("done_cycle", int'(done_out), int'(cyc == exp_done));
                if (done_out) dones++;
            end
        end
        mm_B_valid_in = echo_prev | spur;
        echo_prev     = mm_A_valid_out && !rst_in;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_run(input vec_t v, input string tag);
        int n;
        beats    = 0;
        dones    = 0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n = 0;
        while (dones == 0 && n < 200) begin
            stall_in = (n >= v.stall_after) && (n < v.stall_after + v.stall_len);
            start_in = (n == v.repulse);
            tick();
            n++;
        end
        stall_in = 1'b0;
        start_in = 1'b0;
        if (dones == 0) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_beats"}, beats, v.exp_beats);
        chk({tag, "_dones"}, dones, v.exp_dones);
    endtask

    initial begin
        vecs[0] = '{stall_after: -1, stall_len: 0, repulse: -1, exp_beats: 4, exp_dones: 1};
        vecs[1] = '{stall_after:  2, stall_len: 3, repulse: -1, exp_beats: 4, exp_dones: 1};
        vecs[2] = '{stall_after: -1, stall_len: 0, repulse:  1, exp_beats: 4, exp_dones: 1};

        rst_in   = 1'b1;
        start_in = 1'b0;
        stall_in = 1'b0;
        spur     = 1'b0;
        repeat (3) tick();
        chk("rst_busy",  int'(busy_out), 0);
        chk("rst_done",  int'(done_out), 0);
        chk("rst_err",   int'(err_out), 0);
        chk("rst_valid", int'(mm_A_valid_out | mm_s_valid_out), 0);
        chk("rst_addr",  int'(a_addr_out) + int'(s_addr_out), 0);
        chk("rst_h",     int'(mm_h_out), 0);
        rst_in = 1'b0;
        tick();

        // Table-driven runs: plain, stalled, restart pulse during ISSUE
        for (int t = 0; t < 3; t++) begin
            do_run(vecs[t], $sformatf("vec%0d", t));
            repeat (4) tick();
        end

        // Reset in the middle of ISSUE
        dones    = 0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        chk("midrst_busy",  int'(busy_out), 0);
        chk("midrst_valid", int'(mm_A_valid_out | mm_s_valid_out), 0);
        chk("midrst_done",  int'(done_out), 0);
        rst_in = 1'b0;
        repeat (10) tick();
        chk("midrst_no_done", dones, 0);
        do_run(vecs[0], "after_rst");
        repeat (4) tick();

        // Spurious result in IDLE: sticky error, cleared by the next start
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_err_set", int'(err_out), 1);
        repeat (3) tick();
        chk("spur_err_hold", int'(err_out), 1);
        do_run(vecs[0], "after_spur");
        chk("spur_err_clr", int'(err_out), 0);
        repeat (4) tick();

        // Back-to-back: second start lands the cycle after done
        do_run(vecs[0], "b2b_first");
        do_run(vecs[0], "b2b_second");
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
